// File: rtl/hadamard_16pt_ctrl.sv
// hadamard_16pt_ctrl: frame sequencer for the 16-point Hadamard datapath (hadamard_16pt).
// Latency: 16th sample accept at edge T -> hstart high T+1..T+LAT -> out_valid after edge T+LAT+2.
// Backpressure: in_ready drops while a full frame waits; out_valid/out_data hold until out_ready.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   serial signed 8-bit sample stream (in_data), x0 first
//   hx_flat, hstart     parallel frame and stage enable towards the datapath
//   hy_flat             16 signed 10-bit coefficients from the datapath
//   out_valid/out_ready coefficient stream (out_data, out_idx, out_last)
//   busy                any frame in flight (sequencer active or a buffer occupied)
//
// Build option: define HAD_CTRL_NORM_EN to output coefficients arithmetically
// shifted right by 2 (1/4-scaled transform); timing is identical either way.
module hadamard_16pt_ctrl #(
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic [127:0] hx_flat,
  output logic         hstart,
  input  logic [159:0] hy_flat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [9:0]   out_data,
  output logic [3:0]   out_idx,
  output logic         out_last,
  output logic         busy
);

  localparam int RW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, CAPT} state_t;

  state_t        state;
  logic [RW-1:0] run_cnt;
  logic [3:0]    in_cnt;
  logic          in_full;
  logic          out_busy;
  // Holds in_ready low while reset is asserted; it rises one cycle after release.
  logic          rdy_en;
  logic [7:0]    xbuf [16];
  logic [9:0]    ybuf [16];
  logic [9:0]    raw;

  assign in_ready  = rdy_en & ~in_full;
  assign out_valid = out_busy;
  assign out_last  = out_busy & (out_idx == 4'd15);
  assign busy      = (state != IDLE) | in_full | out_busy | (in_cnt != 4'd0);
  assign raw       = ybuf[out_idx];

`ifdef HAD_CTRL_NORM_EN
  assign out_data = 10'($signed(raw) >>> 2);
`else
  assign out_data = raw;
`endif

  // The frame buffer feeds the datapath directly; it cannot change while
  // in_full is set because no samples are accepted then.
  for (genvar k = 0; k < 16; k++) begin : g_hx
    assign hx_flat[8*k +: 8] = xbuf[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      run_cnt  <= '0;
      hstart   <= 1'b0;
      in_cnt   <= 4'd0;
      in_full  <= 1'b0;
      rdy_en   <= 1'b0;
      out_idx  <= 4'd0;
      out_busy <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        xbuf[k] <= 8'd0;
        ybuf[k] <= 10'd0;
      end
    end else begin
      rdy_en <= 1'b1;

      // Input side: slot in_cnt takes the sample; the 16th beat wraps and marks the frame full.
      if (in_valid && in_ready) begin
        xbuf[in_cnt] <= in_data;
        in_cnt       <= in_cnt + 4'd1;
        if (in_cnt == 4'd15)
          in_full <= 1'b1;
      end

      // Output side: the beat at index 15 ends the drain.
      if (out_busy && out_ready) begin
        out_idx <= out_idx + 4'd1;
        if (out_idx == 4'd15)
          out_busy <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Waiting for the drain keeps the output buffer intact until the
          // previous frame has fully left.
          if (in_full && !out_busy) begin
            state   <= RUN;
            hstart  <= 1'b1;
            run_cnt <= '0;
          end
        end
        RUN: begin
          // LAT enabled cycles with constant inputs overwrite every stage,
          // so nothing stale can reach the capture.
          if (run_cnt == RW'(LAT - 1)) begin
            state  <= CAPT;
            hstart <= 1'b0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        CAPT: begin
          for (int k = 0; k < 16; k++)
            ybuf[k] <= hy_flat[10*k +: 10];
          out_busy <= 1'b1;
          in_full  <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state  <= IDLE;
          hstart <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hadamard_16pt_ctrl.sv
// Bench for hadamard_16pt_ctrl with a behavioural stand-in for the 4-stage datapath.
module tb_hadamard_16pt_ctrl;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [127:0] hx_flat;
  logic         hstart;
  logic [159:0] hy_flat;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [9:0]   out_data;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         busy;

  always #5 clk = ~clk;

  hadamard_16pt_ctrl #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hx_flat(hx_flat), .hstart(hstart), .hy_flat(hy_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- datapath stand-in: fast butterflies, 4 enabled stages ----
  function automatic logic [159:0] fwht(input logic [127:0] hx);
    int v [16];
    int a, b;
    logic [159:0] r;
    for (int n = 0; n < 16; n++) v[n] = int'($signed(hx[8*n +: 8]));
    for (int h = 1; h < 16; h = h * 2)
      for (int i = 0; i < 16; i++)
        if ((i & h) == 0) begin
          a = v[i]; b = v[i+h];
          v[i] = a + b; v[i+h] = a - b;
        end
    for (int k = 0; k < 16; k++) r[10*k +: 10] = v[k][9:0];
    return r;
  endfunction

  // Non-zero power-up contents stand in for stale pipeline state.
  logic [159:0] st0 = {5{32'hA5C3_1E7F}};
  logic [159:0] st1 = {5{32'h5A3C_E1F7}};
  logic [159:0] st2 = {5{32'h3C5A_7FE1}};
  logic [159:0] st3 = {5{32'hC3A5_F71E}};
  always @(posedge clk)
    if (hstart) begin
      st0 <= fwht(hx_flat);
      st1 <= st0;
      st2 <= st1;
      st3 <= st2;
    end
  assign hy_flat = st3;

  // ---------------- reference model: matrix form over the accepted samples ---
  logic signed [7:0] frm [16];
  int exp_q [$];
  int frames_sent = 0;

  function automatic int ref_coef(input int k);
    int s = 0;
    logic signed [9:0] t;
    for (int n = 0; n < 16; n++)
      if ($countones(k & n) % 2 == 1) s -= int'(frm[n]);
      else s += int'(frm[n]);
    t = s[9:0];
`ifdef HAD_CTRL_NORM_EN
    t = t >>> 2;
`endif
    return int'(t);
  endfunction

  task automatic send_frame(input int gap_pct);
    int i = 0;
    int g = 0;
    bit acc;
    while (i < 16 && g < 400) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = frm[i];
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
      g++;
    end
    #1;
    in_valid = 1'b0;
    if (i < 16) chk("in_timeout", i, 16);
    for (int k = 0; k < 16; k++) exp_q.push_back(ref_coef(k));
    frames_sent++;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || exp_q.size() != 0) && g < 1000) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 1000) chk("idle_timeout", g, 0);
  endtask

  task automatic rand_frame();
    for (int n = 0; n < 16; n++) frm[n] = 8'(int'($urandom_range(63)) - 32);
  endtask

  // ---------------- output driver and monitor -------------------------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit       mon_on = 1'b0;
  int       rdy_mode = 0;
  int       runs = 0;
  int       run_len = 0;
  int       beat = 0;
  int       last_edge = 0;
  int       pend_hits = 0;
  bit       pend = 1'b0;
  bit       stalled = 1'b0;
  logic [9:0] held_d;
  logic [3:0] held_i;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(1));
    endcase
    if (!mon_on) begin
      run_len = 0; beat = 0; stalled = 1'b0; pend = 1'b0;
    end else begin
      if (hstart) begin
        if (run_len == 0) begin
          runs++;
          chk("run_has_frame", int'(runs <= frames_sent), 1);
          if (pend) begin
            chk("run_after_drain", cyc, last_edge + 1);
            pend_hits++;
            pend = 1'b0;
          end
        end
        run_len++;
      end else if (run_len != 0) begin
        chk("run_len", run_len, LAT);
        run_len = 0;
      end
      if (stalled) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(held_d));
        chk("stall_idx", int'(out_idx), int'(held_i));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else chk("data", int'($signed(out_data)), exp_q.pop_front());
        chk("idx", int'(out_idx), beat);
        chk("last", int'(out_last), int'(beat == 15));
        if (beat == 15) begin
          last_edge = cyc + 1;
          pend = !in_ready;
          beat = 0;
        end else begin
          beat++;
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_i  = out_idx;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus -------------------------------------------------
  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_hstart", int'(hstart), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hx", int'(hx_flat != 128'd0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    mon_on = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_hstart", int'(hstart), 0);

    // Impulse with latency and in_ready timing.
    for (int i = 0; i < 16; i++) frm[i] = 8'sd0;
    frm[0] = 8'sd5;
    send_frame(0);
    chk("in_ready_drop", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("first_valid_lat", n, LAT + 2);
    chk("in_ready_rise", int'(in_ready), 1);
    wait_idle();

    // DC and mixed-sign frames.
    for (int i = 0; i < 16; i++) frm[i] = 8'sd1;
    send_frame(0);
    wait_idle();
    for (int i = 0; i < 16; i++) frm[i] = (i < 8) ? 8'sd3 : -8'sd3;
    send_frame(0);
    wait_idle();

    // Toggled backpressure with a second frame loaded during the drain.
    rdy_mode = 1;
    rand_frame(); send_frame(0);
    rand_frame(); send_frame(0);
    wait_idle();
    chk("pend_seen", int'(pend_hits > 0), 1);

    // Random input gaps and random consumer stalls.
    rdy_mode = 2;
    repeat (3) begin
      rand_frame(); send_frame(60);
    end
    wait_idle();

    // Reset in the middle of a run, then a fresh impulse at x3.
    rdy_mode = 0;
    rand_frame(); send_frame(0);
    n = 0;
    while (!hstart && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_run_seen", int'(hstart), 1);
    mon_on = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_hstart", int'(hstart), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    exp_q.delete();
    frames_sent--;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", int'(in_ready), 1);
    mon_on = 1'b1;
    for (int i = 0; i < 16; i++) frm[i] = 8'sd0;
    frm[3] = -8'sd7;
    send_frame(0);
    wait_idle();

    rdy_mode = 2;
    repeat (2) begin
      rand_frame(); send_frame(20);
    end
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    chk("runs_match", runs, frames_sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hadamard_16pt_ctrl.md
# hadamard_16pt_ctrl

Frame sequencer for the 16-point Hadamard datapath (`hadamard_16pt`, 4 registered stages, all gated by a shared `start` enable).
- Collects a serial stream of 16 signed 8-bit samples into a frame buffer.
- Drives the datapath's parallel inputs and `start` for exactly one full pipeline flush per frame.
- Captures the 16 signed 10-bit coefficients and streams them out with a valid/ready handshake.

Sits between the sample source and the coefficient consumer. Instantiates nothing; the datapath connects via the `hx_*`/`hy_*`/`hstart` ports.

## Interface
- `LAT`, 4: number of `start`-enabled cycles needed to flush one frame through the datapath.
- `clk`  in  1  clock; single clock domain, all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  controller can accept a sample.
- `in_data`  in  8  signed sample; the first accepted sample of a frame is x0, the 16th is x15.
- `hx_flat`  out  128  datapath inputs; x(k) = `hx_flat[8k+7:8k]`.
- `hstart`  out  1  datapath stage enable.
- `hy_flat`  in  160  datapath outputs; y(k) = `hy_flat[10k+9:10k]`.
- `out_valid`  out  1  coefficient present.
- `out_ready`  in  1  consumer accepts coefficient.
- `out_data`  out  10  signed coefficient y(`out_idx`).
- `out_idx`  out  4  coefficient index, 0..15.
- `out_last`  out  1  high with `out_idx`==15.
- `busy`  out  1  high in RUN or CAPT, or while the frame buffer or output buffer is occupied.

## Operation
- **Reset values.** All outputs are 0 except `in_ready`, which is 1 one cycle after reset deasserts. Internally, `in_cnt`, `out_idx`, `in_full`, `out_busy` and the FSM are cleared to 0/IDLE.
- **Input side.**
  - `in_ready` = !`in_full`.
  - Each accepted beat (`in_valid && in_ready`) writes `in_data` to slot `in_cnt` and increments `in_cnt`.
  - On the 16th beat, `in_cnt` wraps to 0 and `in_full` is set.
  - `hx_flat` is driven directly from the frame buffer and is stable while `in_full`=1.
- **FSM states:** IDLE, RUN, CAPT.
  - IDLE -> RUN when `in_full` && !`out_busy`.
  - RUN: `hstart`=1; a run counter counts LAT cycles, then -> CAPT.
  - CAPT: `hstart`=0; register all 16 values of `hy_flat` into the output buffer; set `out_busy`, clear `in_full`; -> IDLE.
- **Output side.**
  - `out_valid` = `out_busy`.
  - `out_data` = output buffer[`out_idx`].
  - Each handshake increments `out_idx`. The handshake at index 15 wraps `out_idx` to 0 and clears `out_busy`.
- **Overlap.** A new frame loads (`in_full`=0 after CAPT) while the previous frame drains. A new RUN starts only after the drain completes.
- **Run length.** Because `hx_flat` is held constant for all LAT enabled cycles, every datapath stage is overwritten within the run. Stale pipeline contents, including post-reset X, never reach the output buffer.
- **Arithmetic.** Coefficients pass through unmodified; no saturation is applied in this block.

## Timing
- Accept of the 16th sample at edge T -> `in_full`=1 after T.
  - With `out_busy`=0: RUN entered at T+1, `hstart` high for cycles T+1..T+LAT, CAPT at T+LAT+1.
  - `out_valid` rises after edge T+LAT+2.
- Minimum frame period is 16 output beats plus LAT+2 cycles, since RUN waits for the drain.
- Last drain beat at edge D with a pending full frame -> RUN begins at D+1.
- `in_ready` drops in the cycle after the 16th accept and rises the cycle after CAPT.
- `out_valid` is held with stable data until `out_ready`; back-to-back beats are allowed.
- `rst_n`=0 mid-RUN or mid-drain: the partial frame and output are discarded and `hstart` is 0 on the next cycle.

## Configuration
- `HAD_CTRL_NORM_EN`:
  - Defined: `out_data` = output buffer value arithmetically shifted right by 2 (floor, sign-extended to 10 bits), giving a 1/4-scaled transform.
  - Undefined: raw coefficients are output.
- All timing is identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles -> all outputs 0; `in_ready`=1 after release; `hstart` never pulses without a full frame.
- Impulse: x0=5, others 0, `out_ready`=1 -> 16 beats of `out_data`=5, `out_idx` 0..15, `out_last` on beat 16, first `out_valid` LAT+2 cycles after the 16th accept. With NORM_EN: `out_data`=1.
- DC: all 16 samples = 1 -> y0=16, y1..y15=0. With NORM_EN: y0=4. Mixed signs: x0..x7=3, x8..x15=-3 -> y8=48, all other coefficients 0.
- Backpressure: `out_ready` toggled 1-cycle on/off -> data and `out_idx` stable while stalled, no beats lost or duplicated; a second frame loaded during the drain starts RUN the cycle after the last beat.
- Input gaps: `in_valid` asserted randomly across 40 cycles -> frame assembled in order; `hstart` high exactly LAT consecutive cycles per frame.
- Reset mid-RUN, then a new impulse frame x3=-7 -> output matches the Hadamard transform of the new frame only (row 3 signs × -7), with no residue of the aborted frame.
